// File: rtl/vga_store_bridge_pkg.sv
// Shared definitions for the VGA text-window store bridge and its address decoder.
package vga_store_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_FILL,
      ST_DONE,
      ST_ERR
   } state_t;

   // Size codes match the core's mem_write_size encoding.
   localparam logic [1:0] SIZE_NONE = 2'b00;
   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam int VGA_ADDR_W = 13;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_8000;
   localparam int DEF_NUM_CHARS = 4800;
   localparam logic [VGA_ADDR_W-1:0] DEF_CTRL_OFFSET = 13'h1FFC;

   function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_to_nbytes = 3'd1;
         SIZE_HALF: size_to_nbytes = 3'd2;
         SIZE_WORD: size_to_nbytes = 3'd4;
         default:   size_to_nbytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vga_addr_decode.sv
// Combinational decode of a store address against the 8 KiB VGA text window.
// Shared by the store bridge and, later, the load-side MMIO path.
module vga_addr_decode
   import vga_store_bridge_pkg::*;
#(
   parameter logic [31:0]            BASE_ADDR   = DEF_BASE_ADDR,
   parameter int                     NUM_CHARS   = DEF_NUM_CHARS,
   parameter logic [VGA_ADDR_W-1:0]  CTRL_OFFSET = DEF_CTRL_OFFSET
) (
   input  logic                  valid,
   input  logic [31:0]           addr,
   input  logic [1:0]            size,
   output logic                  hit,
   output logic [VGA_ADDR_W-1:0] offset,
   output logic [2:0]            nbytes,
   output logic                  misaligned,
   output logic                  is_ctrl,
   output logic                  out_of_range
);

   localparam logic [VGA_ADDR_W:0] CELL_LIMIT = (VGA_ADDR_W + 1)'(NUM_CHARS);

   logic [VGA_ADDR_W:0] last_byte;

   // One extra bit so an access near the top of the window cannot wrap past the limit.
   assign offset       = addr[VGA_ADDR_W-1:0];
   assign nbytes       = size_to_nbytes(size);
   assign hit          = valid && (size != SIZE_NONE)
                         && (addr[31:VGA_ADDR_W] == BASE_ADDR[31:VGA_ADDR_W]);
   assign misaligned   = ((size == SIZE_HALF) && offset[0])
                         || ((size == SIZE_WORD) && (offset[1:0] != 2'b00));
   assign is_ctrl      = (offset == CTRL_OFFSET);
   assign last_byte    = {1'b0, offset} + {{(VGA_ADDR_W - 2){1'b0}}, nbytes} - 14'd1;
   assign out_of_range = (last_byte >= CELL_LIMIT);

endmodule

// File: rtl/vga_store_bridge.sv
// Store bridge from the core's store path to the ASCII VGA controller: splits
// stores into per-byte character writes and handles the screen-fill control word.
module vga_store_bridge
   import vga_store_bridge_pkg::*;
#(
   parameter int                     WORD_SIZE   = 32,
   parameter logic [31:0]            BASE_ADDR   = DEF_BASE_ADDR,
   parameter int                     NUM_CHARS   = DEF_NUM_CHARS,
   parameter logic [VGA_ADDR_W-1:0]  CTRL_OFFSET = DEF_CTRL_OFFSET
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [31:0]           req_addr,
   input  logic [WORD_SIZE-1:0]  req_data,
   input  logic [1:0]            req_size,
   output logic                  hit,
   output logic                  req_ready,
   output logic                  done,
   output logic                  error,
   output logic                  busy,
   output logic                  ascii_write_en,
   output logic [VGA_ADDR_W-1:0] ascii_write_address,
   output logic [WORD_SIZE-1:0]  ascii_input
);

   localparam logic [VGA_ADDR_W-1:0] LAST_CELL = VGA_ADDR_W'(NUM_CHARS - 1);

   state_t                  state;
   logic [1:0]              lane;
   logic [1:0]              last_lane;
   logic [1:0]              next_lane;
   logic [VGA_ADDR_W-1:0]   base_off;
   logic [VGA_ADDR_W-1:0]   counter;
   logic [WORD_SIZE-1:0]    data_q;

   logic [VGA_ADDR_W-1:0]   offset;
   logic [2:0]              nbytes;
   logic                    misaligned;
   logic                    is_ctrl;
   logic                    out_of_range;
   logic                    accept;
   logic                    reject;

   vga_addr_decode #(
      .BASE_ADDR   (BASE_ADDR),
      .NUM_CHARS   (NUM_CHARS),
      .CTRL_OFFSET (CTRL_OFFSET)
   ) u_decode (
      .valid        (req_valid),
      .addr         (req_addr),
      .size         (req_size),
      .hit          (hit),
      .offset       (offset),
      .nbytes       (nbytes),
      .misaligned   (misaligned),
      .is_ctrl      (is_ctrl),
      .out_of_range (out_of_range)
   );

   // The control word is exempt from the cell bounds check; it only has to be a word store.
   assign accept    = (state == ST_IDLE) && hit;
   assign reject    = misaligned || (is_ctrl ? (req_size != SIZE_WORD) : out_of_range);
   assign next_lane = lane + 2'd1;

   function automatic logic [WORD_SIZE-1:0] zext(input logic [7:0] ch);
      zext = {{(WORD_SIZE - 8){1'b0}}, ch};
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= ST_IDLE;
         lane                <= 2'd0;
         last_lane           <= 2'd0;
         base_off            <= '0;
         counter             <= '0;
         data_q              <= '0;
         req_ready           <= 1'b1;
         done                <= 1'b0;
         error               <= 1'b0;
         busy                <= 1'b0;
         ascii_write_en      <= 1'b0;
         ascii_write_address <= '0;
         ascii_input         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  base_off  <= offset;
                  data_q    <= req_data;
                  last_lane <= 2'(nbytes - 3'd1);
                  lane      <= 2'd0;
                  counter   <= '0;
                  req_ready <= 1'b0;
                  if (reject) begin
                     state <= ST_ERR;
                     done  <= 1'b1;
                     error <= 1'b1;
                  end else begin
                     // First write goes out on the accept edge so it is visible the next cycle.
                     state               <= is_ctrl ? ST_FILL : ST_ISSUE;
                     busy                <= 1'b1;
                     ascii_write_en      <= 1'b1;
                     ascii_write_address <= is_ctrl ? '0 : offset;
                     ascii_input         <= zext(req_data[7:0]);
                  end
               end
            end

            ST_ISSUE: begin
               if (lane == last_lane) begin
                  state               <= ST_DONE;
                  busy                <= 1'b0;
                  done                <= 1'b1;
                  ascii_write_en      <= 1'b0;
                  ascii_write_address <= '0;
                  ascii_input         <= '0;
               end else begin
                  lane                <= next_lane;
                  ascii_write_address <= base_off + VGA_ADDR_W'(next_lane);
                  ascii_input         <= zext(data_q[{next_lane, 3'b000} +: 8]);
               end
            end

            ST_FILL: begin
               if (counter == LAST_CELL) begin
                  state               <= ST_DONE;
                  busy                <= 1'b0;
                  done                <= 1'b1;
                  ascii_write_en      <= 1'b0;
                  ascii_write_address <= '0;
                  ascii_input         <= '0;
               end else begin
                  counter             <= counter + 1'b1;
                  ascii_write_address <= counter + 1'b1;
               end
            end

            ST_DONE, ST_ERR: begin
               state     <= ST_IDLE;
               done      <= 1'b0;
               error     <= 1'b0;
               req_ready <= 1'b1;
            end

            default: begin
               state          <= ST_IDLE;
               done           <= 1'b0;
               error          <= 1'b0;
               busy           <= 1'b0;
               ascii_write_en <= 1'b0;
               req_ready      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_store_bridge.sv
// Self-checking bench for vga_store_bridge: directed scenarios plus random stores
// compared against a behavioural model of the VGA text-window store rules.
module tb_vga_store_bridge;

   localparam logic [31:0] BASE = 32'h0000_8000;
   localparam int NUM  = 4800;
   localparam int CTRL = 'h1FFC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = 2'b00;
   logic        hit, req_ready, done, error, busy, ascii_write_en;
   logic [12:0] ascii_write_address;
   logic [31:0] ascii_input;

   int checks = 0;
   int errors = 0;
   int obs_addr[$];
   int obs_data[$];
   int exp_addr[$];
   int exp_data[$];

   vga_store_bridge dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_valid           (req_valid),
      .req_addr            (req_addr),
      .req_data            (req_data),
      .req_size            (req_size),
      .hit                 (hit),
      .req_ready           (req_ready),
      .done                (done),
      .error               (error),
      .busy                (busy),
      .ascii_write_en      (ascii_write_en),
      .ascii_write_address (ascii_write_address),
      .ascii_input         (ascii_input)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drives one store for a single cycle, then records every write and the done pulse.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int inject_at, input int max_cyc,
                           output logic hit_seen, output int done_cyc, output logic err_seen,
                           output int busy_bad, output int stray);
      obs_addr.delete();
      obs_data.delete();
      done_cyc = -1;
      err_seen = 1'b0;
      busy_bad = 0;
      stray    = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
      #1 hit_seen = hit;
      @(negedge clk);
      req_valid = 1'b0; req_size = 2'b00;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         if (ascii_write_en) begin
            obs_addr.push_back(int'(ascii_write_address));
            obs_data.push_back(int'(ascii_input));
            if (!busy) busy_bad++;
         end
         if (done) begin
            done_cyc = cyc;
            err_seen = error;
            break;
         end
         if (cyc == inject_at) begin
            req_valid = 1'b1; req_addr = BASE + 32'd7; req_data = 32'h5A; req_size = 2'b01;
         end else if (cyc == inject_at + 1) begin
            req_valid = 1'b0; req_size = 2'b00;
         end
         @(negedge clk);
      end
      req_valid = 1'b0; req_size = 2'b00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (ascii_write_en || done) stray++;
      end
   endtask

   // Reference model: kind 0 ignored, 1 error, 2 character writes, 3 screen fill.
   task automatic build_expect(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                               output int kind);
      int off, n;
      exp_addr.delete();
      exp_data.delete();
      n = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
      if (s == 2'b00 || a < BASE || a > BASE + 32'h1FFF) begin
         kind = 0;
         return;
      end
      off = int'(a - BASE);
      if (off % n != 0)            kind = 1;
      else if (off == CTRL)        kind = (s == 2'b11) ? 3 : 1;
      else if (off + n > NUM)      kind = 1;
      else                         kind = 2;
      if (kind == 2)
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(off + i);
            exp_data.push_back(int'((d >> (8 * i)) & 32'hFF));
         end
      if (kind == 3)
         for (int i = 0; i < NUM; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(int'(d & 32'hFF));
         end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, done, error, busy, ascii_write_en} !== 5'b10000
          || ascii_write_address !== 13'd0 || ascii_input !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_values: got ready=%b done=%b err=%b busy=%b we=%b addr=%0d data=%h, expected 1 0 0 0 0 0 0",
                  req_ready, done, error, busy, ascii_write_en, ascii_write_address, ascii_input);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || ascii_write_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got ready=%b done=%b we=%b, expected 1 0 0",
                  req_ready, done, ascii_write_en);
      end
   endtask

   task automatic test_byte_store();
      logic h, e; int dc, bb, st;
      do_store(BASE + 32'd5, 32'h41, 2'b01, -1, 12, h, dc, e, bb, st);
      checks++;
      if (h !== 1'b1) begin errors++; $display("[TB] FAIL byte_hit: got %b expected 1", h); end
      checks++;
      if (obs_addr.size() != 1) begin
         errors++; $display("[TB] FAIL byte_count: got %0d writes expected 1", obs_addr.size());
      end else if (obs_addr[0] != 5 || obs_data[0] != 'h41) begin
         errors++; $display("[TB] FAIL byte_write: got (%0d,%h) expected (5,41)", obs_addr[0], obs_data[0]);
      end
      checks++;
      if (dc != 2 || e !== 1'b0) begin
         errors++; $display("[TB] FAIL byte_done: got cycle %0d error %b expected cycle 2 error 0", dc, e);
      end
   endtask

   task automatic test_word_store();
      logic h, e; int dc, bb, st;
      int wa[4] = '{8, 9, 10, 11};
      int wd[4] = '{'h41, 'h42, 'h43, 'h44};
      do_store(BASE + 32'd8, 32'h4443_4241, 2'b11, -1, 12, h, dc, e, bb, st);
      checks++;
      if (obs_addr.size() != 4) begin
         errors++; $display("[TB] FAIL word_count: got %0d writes expected 4", obs_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] != wa[i] || obs_data[i] != wd[i]) begin
               errors++;
               $display("[TB] FAIL word_lane%0d: got (%0d,%h) expected (%0d,%h)",
                        i, obs_addr[i], obs_data[i], wa[i], wd[i]);
            end
         end
      end
      checks++;
      if (dc != 5 || e !== 1'b0 || bb != 0) begin
         errors++; $display("[TB] FAIL word_done: got cycle %0d error %b busy_low %0d expected 5 0 0", dc, e, bb);
      end
   endtask

   task automatic test_misaligned();
      logic h, e; int dc, bb, st;
      do_store(BASE + 32'd3, 32'h4241, 2'b10, -1, 12, h, dc, e, bb, st);
      checks++;
      if (dc != 1 || e !== 1'b1 || obs_addr.size() != 0) begin
         errors++; $display("[TB] FAIL half_misaligned: got cycle %0d error %b writes %0d expected 1 1 0", dc, e, obs_addr.size());
      end
      do_store(BASE + 32'd4798, 32'h4443_4241, 2'b11, -1, 12, h, dc, e, bb, st);
      checks++;
      if (dc != 1 || e !== 1'b1 || obs_addr.size() != 0) begin
         errors++; $display("[TB] FAIL word_past_end: got cycle %0d error %b writes %0d expected 1 1 0", dc, e, obs_addr.size());
      end
      do_store(BASE + 32'd4796, 32'h4443_4241, 2'b11, -1, 12, h, dc, e, bb, st);
      checks++;
      if (dc != 5 || e !== 1'b0 || obs_addr.size() != 4) begin
         errors++; $display("[TB] FAIL word_last_cells: got cycle %0d error %b writes %0d expected 5 0 4", dc, e, obs_addr.size());
      end
   endtask

   task automatic test_outside_window();
      logic h, e; int dc, bb, st;
      do_store(32'h0000_0100, 32'h41, 2'b01, -1, 6, h, dc, e, bb, st);
      checks++;
      if (h !== 1'b0 || obs_addr.size() != 0 || dc != -1 || st != 0) begin
         errors++; $display("[TB] FAIL outside_window: got hit %b writes %0d done_cycle %0d expected 0 0 -1", h, obs_addr.size(), dc);
      end
   endtask

   task automatic test_fill();
      logic h, e; int dc, bb, st, bad;
      do_store(BASE + CTRL, 32'h20, 2'b11, 50, NUM + 100, h, dc, e, bb, st);
      bad = -1;
      checks++;
      if (obs_addr.size() != NUM) begin
         errors++; $display("[TB] FAIL fill_count: got %0d writes expected %0d", obs_addr.size(), NUM);
      end else begin
         for (int i = 0; i < NUM; i++)
            if (bad < 0 && (obs_addr[i] != i || obs_data[i] != 'h20)) bad = i;
         if (bad >= 0) begin
            errors++; $display("[TB] FAIL fill_write%0d: got (%0d,%h) expected (%0d,20)", bad, obs_addr[bad], obs_data[bad], bad);
         end
      end
      checks++;
      if (dc != NUM + 1 || e !== 1'b0 || bb != 0 || st != 0) begin
         errors++; $display("[TB] FAIL fill_done: got cycle %0d error %b busy_low %0d stray %0d expected %0d 0 0 0", dc, e, bb, st, NUM + 1);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d; logic [1:0] s; logic h, e; int dc, bb, st, kind, r, mism;
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 99);
         s = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         d = $urandom();
         if (r < 50)      a = BASE + 32'($urandom_range(0, NUM - 1));
         else if (r < 70) a = BASE + 32'($urandom_range(NUM - 6, NUM + 2));
         else if (r < 82) a = BASE + 32'($urandom_range(0, 8191));
         else if (r < 90) a = BASE + CTRL;
         else             a = $urandom();
         build_expect(a, d, s, kind);
         do_store(a, d, s, -1, (kind == 3) ? NUM + 100 : (kind == 0) ? 6 : 12, h, dc, e, bb, st);
         checks++;
         if (h !== (kind != 0)) begin
            errors++; $display("[TB] FAIL rand%0d_hit: got %b expected %b (addr %h size %0d)", it, h, kind != 0, a, s);
         end
         if (kind == 0) begin
            checks++;
            if (obs_addr.size() != 0 || dc != -1) begin
               errors++; $display("[TB] FAIL rand%0d_ignored: got writes %0d done_cycle %0d expected 0 -1", it, obs_addr.size(), dc);
            end
         end else begin
            mism = (obs_addr.size() != exp_addr.size()) ? 1 : 0;
            if (mism == 0)
               for (int i = 0; i < exp_addr.size(); i++)
                  if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) mism = 1;
            checks++;
            if (mism != 0) begin
               errors++; $display("[TB] FAIL rand%0d_writes: got %0d writes expected %0d, content differs (addr %h size %0d data %h)",
                                  it, obs_addr.size(), exp_addr.size(), a, s, d);
            end
            checks++;
            if (dc != ((kind == 1) ? 1 : exp_addr.size() + 1) || e !== (kind == 1)) begin
               errors++; $display("[TB] FAIL rand%0d_done: got cycle %0d error %b expected cycle %0d error %b",
                                  it, dc, e, (kind == 1) ? 1 : exp_addr.size() + 1, kind == 1);
            end
            checks++;
            if (bb != 0 || st != 0) begin
               errors++; $display("[TB] FAIL rand%0d_busy: got busy_low %0d stray %0d expected 0 0", it, bb, st);
            end
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      logic found; int n;
      found = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = BASE + CTRL; req_data = 32'h2A; req_size = 2'b11;
      @(negedge clk);
      req_valid = 1'b0; req_size = 2'b00;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (ascii_write_en && ascii_write_address == 13'd100) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (found !== 1'b1) begin errors++; $display("[TB] FAIL fill_reach_100: got %b expected 1", found); end
      rst = 1'b0;
      #1;
      checks++;
      if ({req_ready, done, error, busy, ascii_write_en} !== 5'b10000
          || ascii_write_address !== 13'd0 || ascii_input !== 32'd0) begin
         errors++; $display("[TB] FAIL abort_reset_values: got ready=%b done=%b err=%b busy=%b we=%b addr=%0d expected 1 0 0 0 0 0",
                            req_ready, done, error, busy, ascii_write_en, ascii_write_address);
      end
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done || ascii_write_en || !req_ready) n++;
      end
      checks++;
      if (n != 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", n); end
   endtask

   initial begin
      test_reset();
      test_byte_store();
      test_word_store();
      test_misaligned();
      test_outside_window();
      test_fill();
      test_random();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
